bcd_to_bin_fsmd: RTL
====================

// Module: bcd_to_bin_fsmd
// PURPOSE
//  Sequential BCD-to-binary converter (reverse double-dabble), the decode-side counterpart of the
//  binary-to-BCD stage feeding the seven-segment path. It takes DIGITS packed BCD digits from the
//  switch/button front end, converts them over BIN_W cycles under a start/ready/done handshake, and
//  presents a stable binary result to downstream FSMD datapaths such as the fibonacci core.
// PARAMETERS
//  DIGITS  4   number of BCD input digits; index 0 = least significant
//  BIN_W   14  binary result width; must be >= ceil(log2(10**DIGITS)); switch front end uses 2/7
// PORTS
//  clk        in   1          system clock, rising edge
//  reset      in   1          asynchronous, active-high; one clock domain only
//  start      in   1          request conversion; sampled only while ready=1
//  bcd_in     in   [3:0] x DIGITS  unpacked array of BCD digits, sampled on the accepting edge
//  ready      out  1          1 only in IDLE; conversion may be requested
//  done_tick  out  1          one-cycle pulse: result (or error) valid
//  bcd_err    out  1          registered; 1 = last request contained a digit > 9
//  bin_out    out  BIN_W      registered binary result; held until next completion
// BEHAVIOUR
//  Reset: state=IDLE, ready=1, done_tick=0, bcd_err=0, bin_out=0, all datapath regs 0.
//  States: IDLE, OP, DONE (one-hot not required).
//  IDLE: ready=1. start=1 on edge k -> load bcd regs from bcd_in, bin reg=0, count=BIN_W-1.
//    If any digit > 9: go DONE directly, bcd_err<=1, bin_out<=0 (no OP cycles).
//    Else: bcd_err<=0, go OP.
//  OP (exactly BIN_W cycles): each cycle shift the concatenation {bcd regs, bin reg} right by 1
//    (LSB of digit 0 enters bin MSB); then in the same cycle every shifted digit >= 8 gets -3.
//    count decrements; on count==0 edge: bin_out <= final bin value, go DONE.
//  DONE (1 cycle): done_tick=1, ready=0; next edge -> IDLE.
//  Latency: start sampled at edge k -> done_tick high in cycle after edge k+BIN_W (valid conversion),
//    after edge k+1 (error path). ready returns the cycle after done_tick.
//  bin_out changes only on the edge entering DONE; stable at all other times.
//  start while OP/DONE: ignored, not queued. bcd_in changes during OP: no effect.
//  start held high continuously: a new conversion begins on each return to IDLE.
//  After BIN_W shifts all bcd regs are 0 for valid input; nonzero residue is a design error
//    (bench assertion), not an output.
//  Reset mid-operation: immediate return to IDLE with reset values; partial result discarded.
//  Max value 10**DIGITS-1 (9999 -> 0x270F) must not truncate given the BIN_W rule.
// STRUCTURE
//  Package bcd_pkg: bcd_digit_t (logic [3:0]), fsmd state enum {IDLE,OP,DONE}, BCD_MAX=4'd9,
//    ADJ_THRESH=4'd8, ADJ_SUB=4'd3.
//  Sub-module bcd_dec_adjust: combinational per-digit correction (d>=8 ? d-3 : d), generate-
//    instantiated DIGITS times. FSM + state/next-state regs + shift datapath in this module.
// TESTING
//  1 bcd_in={0,0,0,0}, start pulse -> done_tick exactly BIN_W+1 cycles after accepting edge,
//    bin_out=0, bcd_err=0, ready low during OP/DONE.
//  2 {9,9,9,9} -> bin_out=14'd9999 (0x270F); {1,2,3,4} -> 1234; {0,0,4,2} -> 42.
//  3 {0,0,10,3} (digit 1 = 0xA) -> done_tick 2 cycles after accept, bcd_err=1, bin_out=0;
//    following valid {0,0,0,7} -> bcd_err=0, bin_out=7.
//  4 start re-pulsed and bcd_in changed mid-OP -> ignored; result equals first request.
//  5 reset asserted mid-OP (count=5) -> ready=1, bin_out=0 asynchronously; new start converts cleanly.
//  6 DIGITS=2, BIN_W=7: exhaustive 00..99 back-to-back with start held high -> bin_out = value each
//    done_tick, no missed or duplicated ticks.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam bcd_digit_t BCD_MAX    = 4'd9;
  localparam bcd_digit_t ADJ_THRESH = 4'd8;
  localparam bcd_digit_t ADJ_SUB    = 4'd3;

  function automatic logic is_bad_digit(input bcd_digit_t d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_to_bin_fsmd_if.sv
// Request/result bundle for bcd_to_bin_fsmd: start plus digits in, handshake and result out.
interface bcd_to_bin_fsmd_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);

  logic                 start;
  bcd_pkg::bcd_digit_t  bcd_in [DIGITS];
  logic                 ready;
  logic                 done_tick;
  logic                 bcd_err;
  logic [BIN_W-1:0]     bin_out;

  modport master (
    output start,
    output bcd_in,
    input  ready,
    input  done_tick,
    input  bcd_err,
    input  bin_out
  );

  modport slave (
    input  start,
    input  bcd_in,
    output ready,
    output done_tick,
    output bcd_err,
    output bin_out
  );

endinterface

// File: rtl/bcd_dec_adjust.sv
// Per-digit correction applied after each right shift: digits that reached 8 or more lose 3.
module bcd_dec_adjust
  import bcd_pkg::*;
(
  input  bcd_digit_t d_in,
  output bcd_digit_t d_out
);

  assign d_out = (d_in >= ADJ_THRESH) ? (d_in - ADJ_SUB) : d_in;

endmodule

// File: rtl/bcd_to_bin_fsmd.sv
// Reverse double-dabble BCD-to-binary converter: one shift/adjust step per cycle for BIN_W cycles,
// with a start/ready/done handshake and a flag for requests holding a non-decimal digit.
module bcd_to_bin_fsmd
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic clk,
  input  logic reset,
  bcd_to_bin_fsmd_if.slave bus
);

  localparam int                 CNT_W    = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(BIN_W - 1);

  state_t             state_q, state_d;
  bcd_digit_t         bcd_q [DIGITS];
  bcd_digit_t         bcd_d [DIGITS];
  // Bit 0 of the shift register is never read back, so only the upper bits are stored.
  logic [BIN_W-1:1]   bin_q, bin_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic               err_q, err_d;

  bcd_digit_t         shifted [DIGITS];
  bcd_digit_t         adjusted [DIGITS];
  logic [BIN_W-1:0]   bin_shift;
  logic               any_bad_q;

  // Each digit takes the LSB of the digit above it; the top digit is filled with zero.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi == DIGITS - 1) begin : g_top
        assign shifted[gi] = {1'b0, bcd_q[gi][3:1]};
      end else begin : g_mid
        assign shifted[gi] = {bcd_q[gi+1][0], bcd_q[gi][3:1]};
      end

      bcd_dec_adjust u_adj (
        .d_in  (shifted[gi]),
        .d_out (adjusted[gi])
      );
    end
  endgenerate

  assign bin_shift = {bcd_q[0][0], bin_q};

  always_comb begin
    any_bad_q = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (is_bad_digit(bcd_q[i])) begin
        any_bad_q = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    count_d   = count_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bcd_d   = bus.bcd_in;
          bin_d   = '0;
          count_d = CNT_LOAD;
          state_d = OP;
        end
      end

      OP: begin
        // Digits are validated from the registers on the first OP cycle, so a bad request
        // reports one cycle after acceptance without performing any shifts.
        if ((count_q == CNT_LOAD) && any_bad_q) begin
          err_d     = 1'b1;
          bin_out_d = '0;
          state_d   = DONE;
        end else begin
          bcd_d   = adjusted;
          bin_d   = bin_shift[BIN_W-1:1];
          count_d = count_q - 1'b1;
          if (count_q == '0) begin
            err_d     = 1'b0;
            bin_out_d = bin_shift;
            state_d   = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      count_q   <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        bcd_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      count_q   <= count_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
      for (int i = 0; i < DIGITS; i++) begin
        bcd_q[i] <= bcd_d[i];
      end
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.done_tick = (state_q == DONE);
  assign bus.bcd_err   = err_q;
  assign bus.bin_out   = bin_out_q;

endmodule
